// File: rtl/pmem_line_burst_responder.sv
// Line-to-burst bridge between the L1 cache pmem port and burst memory.
// Each whole-line request becomes one BEATS-beat burst; reads are assembled, writes are split.
//
// state | meaning
// IDLE  | waiting for line_read/line_write, latches address and write line on accept
// WRITE | burst_write held, one latched beat presented per burst_resp
// READ  | burst_read held, each burst_resp beat stored into line_rdata
// DONE  | one-cycle line_resp, always returns to IDLE
module pmem_line_burst_responder #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [ADDR_W-1:0] line_address,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,
    output logic [ADDR_W-1:0] burst_address,
    output logic              burst_read,
    output logic              burst_write,
    output logic [BEAT_W-1:0] burst_wdata,
    input  logic [BEAT_W-1:0] burst_rdata,
    input  logic              burst_resp
);

    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFS_W = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              last_beat;

    assign last_beat = (cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        burst_read  = 1'b0;
        burst_write = 1'b0;
        line_resp   = 1'b0;
        burst_wdata = '0;
        case (state)
            IDLE: begin
                // write wins when both requests are high
                if (line_write) begin
                    state_nxt = WRITE;
                end else if (line_read) begin
                    state_nxt = READ;
                end
            end
            WRITE: begin
                burst_write = 1'b1;
                burst_wdata = wdata_q[cnt*BEAT_W +: BEAT_W];
                if (burst_resp && last_beat) begin
                    state_nxt = DONE;
                end
            end
            READ: begin
                burst_read = 1'b1;
                if (burst_resp && last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                line_resp = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // counter parks on the last beat through DONE and is only cleared on the next accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            line_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_write || line_read) begin
                        addr_q  <= {line_address[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
                        wdata_q <= line_wdata;
                        cnt     <= '0;
                    end
                end
                WRITE: begin
                    if (burst_resp && !last_beat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READ: begin
                    if (burst_resp) begin
                        line_rdata[cnt*BEAT_W +: BEAT_W] <= burst_rdata;
                        if (!last_beat) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign burst_address = addr_q;

endmodule
